uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Consumes ASCII bytes from the UART RX FIFO and turns them into one-cycle control pulses and a time-set load for the stopwatch/watch/sensor control units. It sits directly downstream of `uart_top`: it drives `pop` and reads `rx_fifo_data` whenever `rx_empty` is low. Single-byte commands produce immediate pulses. The framed command `T` followed by six digits (HHMMSS) produces a validated time load.

## Interface
- `TIMEOUT_CYCLES`, default 100_000_000: idle clocks allowed between bytes of a `T` frame (1 s at 100 MHz).
- `clk` input, 1: system clock, 100 MHz.
- `rst` input, 1: synchronous, active-high reset.
- `rx_empty` input, 1: RX FIFO empty flag.
- `rx_fifo_data` input, 8: RX FIFO head byte (show-ahead), valid whenever `rx_empty`=0.
- `pop` output, 1: consume the head byte this cycle.
- `cmd_run_stop` output, 1: one-cycle pulse, run/stop toggle.
- `cmd_clear` output, 1: one-cycle pulse, clear.
- `cmd_mode` output, 1: one-cycle pulse, stopwatch/watch mode toggle.
- `cmd_sensor` output, 1: one-cycle pulse, start a distance measurement.
- `set_time` output, 1: one-cycle pulse; `set_hour`/`set_min`/`set_sec` are valid in the same cycle.
- `set_hour` output, 5: 0–23, held until the next `set_time`.
- `set_min` output, 6: 0–59, held until the next `set_time`.
- `set_sec` output, 6: 0–59, held until the next `set_time`.
- `cmd_err` output, 1: one-cycle pulse for an unknown byte, a bad digit, an out-of-range value, or a timeout.

## Operation
- `pop` is combinational: `pop = ~rx_empty & ~rst`. Every byte is consumed in the cycle it is presented.
- Throughput is one byte per clock.
- FSM states: `IDLE`, `DIG` (with digit index `idx` 0–5).
- In `IDLE`, decoding is case-insensitive:
  - `R` → `cmd_run_stop`
  - `C` → `cmd_clear`
  - `M` → `cmd_mode`
  - `D` → `cmd_sensor`
  - `T` → go to `DIG` with `idx`=0, clear the digit registers and the timeout counter.
  - CR (0x0D), LF (0x0A) and space (0x20) are ignored silently.
  - Any other byte → `cmd_err`.
- In `DIG`:
  - An ASCII `0`–`9` stores a 4-bit digit at `idx` and increments `idx`.
  - Any other byte (including CR/LF or a command letter) aborts: `cmd_err`, return to `IDLE`. The byte is discarded, not reinterpreted.
- When the 6th digit is accepted:
  - hour = 10·d0+d1, min = 10·d2+d3, sec = 10·d4+d5.
  - If hour≤23, min≤59 and sec≤59: pulse `set_time` and update the `set_*` registers.
  - Otherwise: pulse `cmd_err` and leave the `set_*` registers unchanged.
  - Either way, return to `IDLE`.
- Timeout: in `DIG`, a counter increments on every cycle with no pop and resets on every accepted byte. When it reaches `TIMEOUT_CYCLES`-1: pulse `cmd_err`, return to `IDLE`.
- At most one output pulse is asserted per cycle (one byte per cycle).

## Timing
- A byte popped at cycle N produces its pulse (`cmd_*`, `set_time` or `cmd_err`) registered at N+1.
- The `set_*` values update at the same edge as `set_time`.
- A timeout `cmd_err` occurs exactly `TIMEOUT_CYCLES` cycles after the last accepted digit, or after the `T`.
- Back-to-back bytes on consecutive cycles are each decoded; there are no bubbles.
- Timeout and a byte arriving in the same cycle: the byte wins and the counter resets.
- Reset values: FSM `IDLE`, `idx`=0, counter=0, all pulses 0, `set_hour`/`set_min`/`set_sec`=0. `pop`=0 while `rst`=1.
- Reset mid-frame discards the partial frame; no pulse is produced.

## Structure
- A shared package/header `uart_cmd_pkg` holds:
  - the ASCII constants (`R`/`r`, `C`/`c`, `M`/`m`, `D`/`d`, `T`/`t`, CR, LF, SP, `0`, `9`);
  - the FSM state encoding;
  - the field widths (5/6/6).
- One sub-module, `cmd_timeout_timer`:
  - inputs `clk`, `rst`, `clr`, `en`; output `expire`;
  - counter width `$clog2(TIMEOUT_CYCLES)`.
- Digit storage, range check and pulse registers stay in the top module.

## Test plan
- `r`, `C`, `m`, `D` on consecutive cycles → `pop` for 4 cycles; `cmd_run_stop`, `cmd_clear`, `cmd_mode`, `cmd_sensor` each pulse once, each one cycle after its pop.
- `T`,`1`,`2`,`3`,`4`,`5`,`6` → single `set_time` pulse with `set_hour`=12, `set_min`=34, `set_sec`=56; no `cmd_err`.
- `T` then `245959` → `cmd_err` after the 6th digit; `set_*` keep their previous values. `T` then `0A` → `cmd_err` on `A`, FSM back in `IDLE`, and the next `r` still yields `cmd_run_stop`.
- With `TIMEOUT_CYCLES`=16: `T`,`1`, then FIFO empty → `cmd_err` exactly 16 cycles after `1`. A byte arriving on the expiry cycle suppresses the error.
- `X`, CR, LF, space → one `cmd_err` (for `X`) and nothing else. `rx_empty`=1 throughout a window → `pop`=0 and no pulses.
- Assert `rst` after `T12` → all outputs 0. Then `345678` → six `cmd_err` pulses (the digits now arrive in `IDLE`) and no `set_time`.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command decoder: ASCII codes, FSM encoding, time field widths.
package uart_cmd_pkg;

    localparam logic [7:0] ASC_R   = 8'h52;
    localparam logic [7:0] ASC_R_L = 8'h72;
    localparam logic [7:0] ASC_C   = 8'h43;
    localparam logic [7:0] ASC_C_L = 8'h63;
    localparam logic [7:0] ASC_M   = 8'h4D;
    localparam logic [7:0] ASC_M_L = 8'h6D;
    localparam logic [7:0] ASC_D   = 8'h44;
    localparam logic [7:0] ASC_D_L = 8'h64;
    localparam logic [7:0] ASC_T   = 8'h54;
    localparam logic [7:0] ASC_T_L = 8'h74;
    localparam logic [7:0] ASC_CR  = 8'h0D;
    localparam logic [7:0] ASC_LF  = 8'h0A;
    localparam logic [7:0] ASC_SP  = 8'h20;
    localparam logic [7:0] ASC_0   = 8'h30;
    localparam logic [7:0] ASC_9   = 8'h39;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int IDX_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        DIG  = 1'b1
    } state_t;

    // Two decimal digits to binary; 7 bits covers the 0..99 range seen before the range check.
    function automatic logic [6:0] bcd_pair(input logic [3:0] tens, input logic [3:0] ones);
        return ({3'b000, tens} * 7'd10) + {3'b000, ones};
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte timeout for a time-set frame: expire fires in the cycle whose edge brings the
// count to TIMEOUT_CYCLES-1, so the registered error lands TIMEOUT_CYCLES cycles after the last byte.
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    assign expire = en & ~clr & (cnt == CW'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Pops every RX FIFO byte as it appears and decodes it into one-cycle command pulses
// or a range-checked HHMMSS time load; all pulses are registered one cycle after the pop.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_empty,
    input  logic [7:0]        rx_fifo_data,
    output logic              pop,
    output logic              cmd_run_stop,
    output logic              cmd_clear,
    output logic              cmd_mode,
    output logic              cmd_sensor,
    output logic              set_time,
    output logic [HOUR_W-1:0] set_hour,
    output logic [MIN_W-1:0]  set_min,
    output logic [SEC_W-1:0]  set_sec,
    output logic              cmd_err
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [3:0]       dig [0:4];

    logic run_nxt, clr_nxt, mode_nxt, sns_nxt, set_nxt, err_nxt;
    logic dig_clr, dig_we;
    logic expire;
    logic is_digit;
    logic [3:0] cur_digit;
    logic [6:0] hour_v, min_v, sec_v;
    logic       in_range;

    assign pop       = ~rx_empty & ~rst;
    assign is_digit  = (rx_fifo_data >= ASC_0) && (rx_fifo_data <= ASC_9);
    assign cur_digit = rx_fifo_data[3:0];

    // The sixth digit is never stored; it feeds the seconds value straight from the FIFO head.
    assign hour_v   = bcd_pair(dig[0], dig[1]);
    assign min_v    = bcd_pair(dig[2], dig[3]);
    assign sec_v    = bcd_pair(dig[4], cur_digit);
    assign in_range = (hour_v <= 7'd23) && (min_v <= 7'd59) && (sec_v <= 7'd59);

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   ((state == IDLE) | pop),
        .en    ((state == DIG) & ~pop),
        .expire(expire)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        run_nxt   = 1'b0;
        clr_nxt   = 1'b0;
        mode_nxt  = 1'b0;
        sns_nxt   = 1'b0;
        set_nxt   = 1'b0;
        err_nxt   = 1'b0;
        dig_clr   = 1'b0;
        dig_we    = 1'b0;

        case (state)
            IDLE: begin
                if (pop) begin
                    case (rx_fifo_data)
                        ASC_R, ASC_R_L: run_nxt  = 1'b1;
                        ASC_C, ASC_C_L: clr_nxt  = 1'b1;
                        ASC_M, ASC_M_L: mode_nxt = 1'b1;
                        ASC_D, ASC_D_L: sns_nxt  = 1'b1;
                        ASC_T, ASC_T_L: begin
                            state_nxt = DIG;
                            idx_nxt   = '0;
                            dig_clr   = 1'b1;
                        end
                        ASC_CR, ASC_LF, ASC_SP: ;
                        default: err_nxt = 1'b1;
                    endcase
                end
            end
            DIG: begin
                if (pop) begin
                    if (!is_digit) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else if (idx == IDX_W'(5)) begin
                        set_nxt   = in_range;
                        err_nxt   = ~in_range;
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        dig_we  = 1'b1;
                        idx_nxt = idx + IDX_W'(1);
                    end
                end else if (expire) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            cmd_run_stop <= 1'b0;
            cmd_clear    <= 1'b0;
            cmd_mode     <= 1'b0;
            cmd_sensor   <= 1'b0;
            set_time     <= 1'b0;
            cmd_err      <= 1'b0;
            set_hour     <= '0;
            set_min      <= '0;
            set_sec      <= '0;
            for (int i = 0; i < 5; i++) dig[i] <= '0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            cmd_run_stop <= run_nxt;
            cmd_clear    <= clr_nxt;
            cmd_mode     <= mode_nxt;
            cmd_sensor   <= sns_nxt;
            set_time     <= set_nxt;
            cmd_err      <= err_nxt;
            for (int i = 0; i < 5; i++) begin
                if (dig_clr) begin
                    dig[i] <= '0;
                end else if (dig_we && (idx == IDX_W'(i))) begin
                    dig[i] <= cur_digit;
                end
            end
            if (set_nxt) begin
                set_hour <= HOUR_W'(hour_v);
                set_min  <= MIN_W'(min_v);
                set_sec  <= SEC_W'(sec_v);
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench: the driver queues each expected pulse with its cycle, a negedge monitor matches them.
module tb_uart_cmd_decoder;

    localparam int TO = 16;

    localparam logic [5:0] K_RUN  = 6'b000001;
    localparam logic [5:0] K_CLR  = 6'b000010;
    localparam logic [5:0] K_MODE = 6'b000100;
    localparam logic [5:0] K_SNS  = 6'b001000;
    localparam logic [5:0] K_SET  = 6'b010000;
    localparam logic [5:0] K_ERR  = 6'b100000;
    localparam logic [5:0] K_NONE = 6'b000000;

    typedef struct {
        int         cyc;
        logic [5:0] kind;
        int         h;
        int         m;
        int         s;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_empty = 1'b1;
    logic [7:0] rx_fifo_data = 8'h00;
    logic       pop, cmd_run_stop, cmd_clear, cmd_mode, cmd_sensor, set_time, cmd_err;
    logic [4:0] set_hour;
    logic [5:0] set_min, set_sec;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    uart_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_empty    (rx_empty),
        .rx_fifo_data(rx_fifo_data),
        .pop         (pop),
        .cmd_run_stop(cmd_run_stop),
        .cmd_clear   (cmd_clear),
        .cmd_mode    (cmd_mode),
        .cmd_sensor  (cmd_sensor),
        .set_time    (set_time),
        .set_hour    (set_hour),
        .set_min     (set_min),
        .set_sec     (set_sec),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] pulses();
        return {cmd_err, set_time, cmd_sensor, cmd_mode, cmd_clear, cmd_run_stop};
    endfunction

    // Monitor: pop is checked every cycle, any pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (pop !== (~rx_empty & ~rst)) begin
            check("pop", int'(pop), int'(~rx_empty & ~rst));
        end
        if (pulses() != K_NONE) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", int'(pulses()), int'(K_NONE));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", int'(pulses()), int'(e.kind));
                check("pulse_cycle", cyc, e.cyc);
                if (e.kind == K_SET) begin
                    check("set_hour", int'(set_hour), e.h);
                    check("set_min", int'(set_min), e.m);
                    check("set_sec", int'(set_sec), e.s);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic [5:0] kind, input int h, input int m, input int s);
        exp_t e;
        if (kind != K_NONE) begin
            e.cyc = cyc + 1; e.kind = kind; e.h = h; e.m = m; e.s = s;
            sb.push_back(e);
        end
        rx_empty     = 1'b0;
        rx_fifo_data = b;
        @(posedge clk); #1;
        rx_empty     = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_pulses"}, int'(pulses()), int'(K_NONE));
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_hour"}, int'(set_hour), h);
        check({tag, "_min"}, int'(set_min), m);
        check({tag, "_sec"}, int'(set_sec), s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        idle(3);
        check_quiet("reset");
        check_time("reset", 0, 0, 0);
        check("reset_pop", int'(pop), 0);
        rst = 1'b0;
        idle(2);

        // Back-to-back single-byte commands, mixed case
        send("r", K_RUN,  0, 0, 0);
        send("C", K_CLR,  0, 0, 0);
        send("m", K_MODE, 0, 0, 0);
        send("D", K_SNS,  0, 0, 0);
        idle(3);

        // Valid time set 12:34:56
        send("T", K_NONE, 0, 0, 0);
        send("1", K_NONE, 0, 0, 0);
        send("2", K_NONE, 0, 0, 0);
        send("3", K_NONE, 0, 0, 0);
        send("4", K_NONE, 0, 0, 0);
        send("5", K_NONE, 0, 0, 0);
        send("6", K_SET, 12, 34, 56);
        idle(2);
        check_time("after_set", 12, 34, 56);

        // Hour 24 out of range: error, registers held
        send("t", K_NONE, 0, 0, 0);
        send("2", K_NONE, 0, 0, 0);
        send("4", K_NONE, 0, 0, 0);
        send("5", K_NONE, 0, 0, 0);
        send("9", K_NONE, 0, 0, 0);
        send("5", K_NONE, 0, 0, 0);
        send("9", K_ERR,  0, 0, 0);
        idle(2);
        check_time("after_range_err", 12, 34, 56);

        // Bad digit aborts the frame, next command decodes normally
        send("T", K_NONE, 0, 0, 0);
        send("0", K_NONE, 0, 0, 0);
        send("A", K_ERR,  0, 0, 0);
        send("r", K_RUN,  0, 0, 0);
        idle(2);

        // Unknown byte followed by silently ignored whitespace
        send("X",   K_ERR,  0, 0, 0);
        send(8'h0D, K_NONE, 0, 0, 0);
        send(8'h0A, K_NONE, 0, 0, 0);
        send(8'h20, K_NONE, 0, 0, 0);
        idle(10);

        // Timeout: error exactly TO cycles after the pop of the last digit
        send("T", K_NONE, 0, 0, 0);
        c = cyc;
        send("1", K_NONE, 0, 0, 0);
        begin
            exp_t e;
            e.cyc = c + TO; e.kind = K_ERR; e.h = 0; e.m = 0; e.s = 0;
            sb.push_back(e);
        end
        idle(TO + 4);

        // A byte on the expiry cycle wins; frame completes as 12:00:00
        send("T", K_NONE, 0, 0, 0);
        c = cyc;
        send("1", K_NONE, 0, 0, 0);
        while (cyc < c + TO - 1) idle(1);
        send("2", K_NONE, 0, 0, 0);
        send("0", K_NONE, 0, 0, 0);
        send("0", K_NONE, 0, 0, 0);
        send("0", K_NONE, 0, 0, 0);
        send("0", K_SET, 12, 0, 0);
        idle(TO + 4);
        check_time("after_late_byte", 12, 0, 0);

        // Reset mid-frame with a byte waiting: no pop, everything cleared
        send("T", K_NONE, 0, 0, 0);
        send("1", K_NONE, 0, 0, 0);
        send("2", K_NONE, 0, 0, 0);
        rst          = 1'b1;
        rx_empty     = 1'b0;
        rx_fifo_data = "3";
        idle(2);
        check("rst_pop", int'(pop), 0);
        check_quiet("midframe_reset");
        check_time("midframe_reset", 0, 0, 0);
        rst      = 1'b0;
        rx_empty = 1'b1;
        idle(1);
        send("3", K_ERR, 0, 0, 0);
        send("4", K_ERR, 0, 0, 0);
        send("5", K_ERR, 0, 0, 0);
        send("6", K_ERR, 0, 0, 0);
        send("7", K_ERR, 0, 0, 0);
        send("8", K_ERR, 0, 0, 0);
        idle(TO + 4);
        check_time("after_digits_idle", 0, 0, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
